ctrl_barrido_teclado: RTL and testbench

Scan controller for the 4x4 matrix keypad. It drives one-hot column strobes and samples the row inputs. A press is debounced, encoded to a 5-bit key code and offered to the consumer through a single-entry valid/ack buffer. After reporting a key it waits for release before scanning resumes. It sits between the keypad pins (col/fila) and the digit-entry logic that consumes the digito-style codes.

---
 rtl/teclado_pkg.sv | 39 +++
 rtl/ctrl_barrido_teclado_if.sv | 16 +
 rtl/div_barrido.sv | 38 +++
 rtl/ctrl_barrido_teclado.sv | 197 +++++++++++++++++++
 tb/tb_ctrl_barrido_teclado.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/teclado_pkg.sv
// Shared definitions for the 4x4 keypad scan controller.
//   - estado_t       : scan FSM states (BARRIDO, REBOTE, SOLTAR)
//   - TECLA_W        : width of the key code
//   - TECLA_NINGUNA  : key code meaning "no key buffered"
//   - COL_RESET      : column strobe value after reset
//   - codificar()    : (column index, row index) -> key code
//   - fila_prioridad(): lowest set row index of a row vector
package teclado_pkg;

  typedef enum logic [1:0] {
    BARRIDO = 2'd0,
    REBOTE  = 2'd1,
    SOLTAR  = 2'd2
  } estado_t;

  localparam int unsigned        TECLA_W       = 5;
  localparam logic [TECLA_W-1:0] TECLA_NINGUNA = 5'h1F;
  localparam logic [3:0]         COL_RESET     = 4'b0001;

  // Key code is 4*col_idx + fila_idx; the MSB stays 0 so 5'h1F never collides.
  function automatic logic [TECLA_W-1:0] codificar(input logic [1:0] col_idx,
                                                   input logic [1:0] fila_idx);
    return {1'b0, col_idx, fila_idx};
  endfunction

  // Several rows pressed on one column: the lowest index wins.
  function automatic logic [1:0] fila_prioridad(input logic [3:0] f);
    if (f[0]) begin
      return 2'd0;
    end else if (f[1]) begin
      return 2'd1;
    end else if (f[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

endpackage

// File: rtl/ctrl_barrido_teclado_if.sv
// Key hand-off bus between the keypad scanner and the digit-entry consumer.
//   tecla        : buffered key code (TECLA_NINGUNA when empty)
//   tecla_valida : buffer holds an unconsumed key
//   tecla_ack    : consumer takes the key
// master = scanner side, slave = consumer side.
interface ctrl_barrido_teclado_if;
  import teclado_pkg::*;

  logic [TECLA_W-1:0] tecla;
  logic               tecla_valida;
  logic               tecla_ack;

  modport master (output tecla, output tecla_valida, input tecla_ack);
  modport slave  (input tecla, input tecla_valida, output tecla_ack);

endinterface

// File: rtl/div_barrido.sv
// Column dwell divider: counts 0..DIV_BARRIDO-1 and wraps; tick is high on
// the last count of every dwell, which is when the rows are sampled.
// Ports: clk, rst (synchronous, active-high), tick (one cycle per dwell).
module div_barrido #(
  parameter int unsigned DIV_BARRIDO = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned   W          = $clog2(DIV_BARRIDO);
  localparam logic [W-1:0]  CUENTA_MAX = W'(DIV_BARRIDO - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tick = (cnt_q == CUENTA_MAX);

  // Next count: wrap after the last dwell cycle
  always_comb begin
    if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Dwell counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_barrido_teclado.sv
// 4x4 matrix keypad scan controller.
// Strobes one column at a time, samples the rows once per dwell, debounces a
// press over N_DEBOUNCE ticks, encodes it and offers it through a single-entry
// valid/ack buffer, then waits for N_DEBOUNCE release ticks before scanning on.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   fila      : row sense lines (active-high, already synchronised)
//   col       : one-hot column strobe
//   cons      : key hand-off bus (tecla / tecla_valida / tecla_ack), master side
//   sobrecarga: sticky "key dropped while buffer full" flag, only present when
//               TECLADO_SOBRECARGA_EN is defined
module ctrl_barrido_teclado
  import teclado_pkg::*;
#(
  parameter int unsigned DIV_BARRIDO = 1000,
  parameter int unsigned N_DEBOUNCE  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              fila,
  output logic [3:0]              col,
`ifdef TECLADO_SOBRECARGA_EN
  output logic                    sobrecarga,
`endif
  ctrl_barrido_teclado_if.master  cons
);

  localparam int unsigned   WD      = $clog2(N_DEBOUNCE + 1);
  localparam logic [WD-1:0] DEB_MAX = WD'(N_DEBOUNCE);
  localparam logic [WD-1:0] DEB_UNO = WD'(1);

  estado_t            state_q, state_d;
  logic [3:0]         col_q, col_d;
  logic [1:0]         col_idx_q, col_idx_d;
  logic [1:0]         cand_q, cand_d;
  logic [WD-1:0]      deb_q, deb_d;
  logic [TECLA_W-1:0] tecla_q, tecla_d;
  logic               valida_q, valida_d;
`ifdef TECLADO_SOBRECARGA_EN
  logic               sob_q, sob_d;
`endif

  logic               tick_s;
  logic               fila_hay_s;
  logic [1:0]         fila_idx_s;
  logic [WD-1:0]      deb_inc_s;
  logic               aceptar_s;
  logic               rotar_s;
  logic               carga_s;
  logic [TECLA_W-1:0] codigo_s;

  div_barrido #(
    .DIV_BARRIDO(DIV_BARRIDO)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .tick(tick_s)
  );

  assign fila_hay_s = |fila;
  assign fila_idx_s = fila_prioridad(fila);
  assign deb_inc_s  = deb_q + WD'(1);
  // On an accept the sampled row equals the candidate, and col is still held.
  assign codigo_s   = codificar(col_idx_q, fila_idx_s);

  // State register plus all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BARRIDO;
      col_q     <= COL_RESET;
      col_idx_q <= 2'd0;
      cand_q    <= 2'd0;
      deb_q     <= '0;
      tecla_q   <= TECLA_NINGUNA;
      valida_q  <= 1'b0;
`ifdef TECLADO_SOBRECARGA_EN
      sob_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      col_idx_q <= col_idx_d;
      cand_q    <= cand_d;
      deb_q     <= deb_d;
      tecla_q   <= tecla_d;
      valida_q  <= valida_d;
`ifdef TECLADO_SOBRECARGA_EN
      sob_q     <= sob_d;
`endif
    end
  end

  // Next-state logic: scan, debounce and release tracking advance only on ticks
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    deb_d     = deb_q;
    aceptar_s = 1'b0;
    rotar_s   = 1'b0;
    if (tick_s) begin
      case (state_q)
        BARRIDO: begin
          if (fila_hay_s) begin
            cand_d = fila_idx_s;
            if (DEB_UNO == DEB_MAX) begin
              aceptar_s = 1'b1;
              state_d   = SOLTAR;
              deb_d     = '0;
            end else begin
              state_d   = REBOTE;
              deb_d     = DEB_UNO;
            end
          end else begin
            rotar_s = 1'b1;
          end
        end
        REBOTE: begin
          if (fila_hay_s && (fila_idx_s == cand_q)) begin
            if (deb_inc_s == DEB_MAX) begin
              aceptar_s = 1'b1;
              state_d   = SOLTAR;
              deb_d     = '0;
            end else begin
              deb_d     = deb_inc_s;
            end
          end else begin
            // Bounce or different row: abandon and move to the next column
            rotar_s = 1'b1;
            state_d = BARRIDO;
            deb_d   = '0;
          end
        end
        SOLTAR: begin
          if (fila_hay_s) begin
            deb_d = '0;
          end else if (deb_inc_s == DEB_MAX) begin
            rotar_s = 1'b1;
            state_d = BARRIDO;
            deb_d   = '0;
          end else begin
            deb_d = deb_inc_s;
          end
        end
        default: begin
          state_d = BARRIDO;
          deb_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output logic: column rotation and the single-entry key buffer
  always_comb begin
    col_d     = col_q;
    col_idx_d = col_idx_q;
    tecla_d   = tecla_q;
    valida_d  = valida_q;
`ifdef TECLADO_SOBRECARGA_EN
    sob_d     = sob_q;
`endif
    if (rotar_s) begin
      col_d     = {col_q[2:0], col_q[3]};
      col_idx_d = col_idx_q + 2'd1;
    end else begin
      col_d     = col_q;
      col_idx_d = col_idx_q;
    end

    // A same-cycle ack frees the slot, so a load wins over the clear.
    carga_s = aceptar_s && (!valida_q || cons.tecla_ack);
    if (carga_s) begin
      tecla_d  = codigo_s;
      valida_d = 1'b1;
    end else if (aceptar_s) begin
`ifdef TECLADO_SOBRECARGA_EN
      sob_d    = 1'b1;
`else
      tecla_d  = tecla_q;
`endif
    end else if (valida_q && cons.tecla_ack) begin
      tecla_d  = TECLA_NINGUNA;
      valida_d = 1'b0;
    end else begin
      valida_d = valida_q;
    end
  end

  assign col               = col_q;
  assign cons.tecla        = tecla_q;
  assign cons.tecla_valida = valida_q;
`ifdef TECLADO_SOBRECARGA_EN
  assign sobrecarga        = sob_q;
`endif

endmodule

// File: tb/tb_ctrl_barrido_teclado.sv
// Testbench for ctrl_barrido_teclado (DIV_BARRIDO=4, N_DEBOUNCE=3).
// A keypad emulation turns a 16-bit "pressed keys" mask into row lines from
// the live column strobe. A behavioural model predicts col/valid/code each
// cycle and pushes every expected key load into a queue that a separate
// monitor pops whenever the DUT presents a new key.
module tb_ctrl_barrido_teclado;

  localparam int DIV  = 4;
  localparam int NDEB = 3;
  localparam int ESCANEO  = 0;
  localparam int CONFIRMA = 1;
  localparam int ESPERA   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fila;
  logic [3:0]  col;
  logic [15:0] pulsadas;
`ifdef TECLADO_SOBRECARGA_EN
  logic        sobrecarga;
`endif

  ctrl_barrido_teclado_if bus ();

  ctrl_barrido_teclado #(
    .DIV_BARRIDO(DIV),
    .N_DEBOUNCE (NDEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fila(fila),
    .col (col),
`ifdef TECLADO_SOBRECARGA_EN
    .sobrecarga(sobrecarga),
`endif
    .cons(bus)
  );

  always #5 clk = ~clk;

  // Keypad emulation: key k = 4*column + row closes row (k%4) when column (k/4) is strobed
  always_comb begin
    fila = 4'b0000;
    for (int c = 0; c < 4; c++) begin
      if (col[c] === 1'b1) fila = fila | pulsadas[c*4 +: 4];
    end
  end

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  // Model state
  int m_cyc, m_col, m_mode, m_cand, m_cnt, m_tecla;
  bit m_valid, m_sob;
  bit chk_en = 1'b0;
  int k, hold;

  task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
    checks++;
    if (actual !== esperado) begin
      errors++;
      $display("FAIL %s: actual=%0h esperado=%0h t=%0t", nombre, actual, esperado, $time);
    end
  endtask

  function automatic int fila_menor(input logic [3:0] f);
    for (int r = 0; r < 4; r++) begin
      if (f[r] === 1'b1) return r;
    end
    return -1;
  endfunction

  task automatic ciclos(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic esperar_col(input logic [3:0] objetivo, input int limite);
    int n;
    n = 0;
    while (col !== objetivo && n < limite) begin
      ciclos(1);
      n++;
    end
    checks++;
    if (col !== objetivo) begin
      errors++;
      $display("FAIL espera_col: col=%b objetivo=%b tras %0d ciclos", col, objetivo, limite);
    end
  endtask

  task automatic esperar_valida(input int limite);
    int n;
    n = 0;
    while (bus.tecla_valida !== 1'b1 && n < limite) begin
      ciclos(1);
      n++;
    end
    checks++;
    if (bus.tecla_valida !== 1'b1) begin
      errors++;
      $display("FAIL espera_valida: tecla_valida=%b tras %0d ciclos", bus.tecla_valida, limite);
    end
  endtask

  // Reference model: compare current outputs, then predict the next cycle
  initial begin : modelo
    int row;
    int codigo;
    bit tick;
    bit acepta;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("col", {28'd0, col}, 32'd1 << m_col);
        chk("tecla_valida", {31'd0, bus.tecla_valida}, 32'(m_valid));
        chk("tecla", {27'd0, bus.tecla}, 32'(m_tecla));
`ifdef TECLADO_SOBRECARGA_EN
        chk("sobrecarga", {31'd0, sobrecarga}, 32'(m_sob));
`endif
      end
      if (rst === 1'b1) begin
        m_cyc = 0; m_col = 0; m_mode = ESCANEO; m_cand = 0; m_cnt = 0;
        m_valid = 1'b0; m_tecla = 31; m_sob = 1'b0;
        exp_q.delete();
        chk_en = 1'b1;
      end else if (chk_en) begin
        tick = ((m_cyc % DIV) == DIV - 1);
        m_cyc++;
        acepta = 1'b0;
        codigo = 31;
        row = fila_menor(fila);
        if (tick) begin
          if (m_mode == ESCANEO) begin
            if (row < 0) m_col = (m_col + 1) % 4;
            else begin m_cand = row; m_cnt = 1; m_mode = CONFIRMA; end
          end else if (m_mode == CONFIRMA) begin
            if (row == m_cand) m_cnt++;
            else begin m_col = (m_col + 1) % 4; m_mode = ESCANEO; end
          end else begin
            if (row < 0) begin
              m_cnt++;
              if (m_cnt == NDEB) begin m_col = (m_col + 1) % 4; m_mode = ESCANEO; end
            end else m_cnt = 0;
          end
          if (m_mode == CONFIRMA && m_cnt == NDEB) begin
            acepta = 1'b1;
            codigo = 4 * m_col + m_cand;
            m_mode = ESPERA;
            m_cnt  = 0;
          end
        end
        if (acepta && (!m_valid || bus.tecla_ack === 1'b1)) begin
          m_valid = 1'b1;
          m_tecla = codigo;
          exp_q.push_back(codigo);
        end else if (acepta) begin
          m_sob = 1'b1;
        end else if (m_valid && bus.tecla_ack === 1'b1) begin
          m_valid = 1'b0;
          m_tecla = 31;
        end
      end
    end
  end

  // Monitor: each newly presented key must match the oldest expected load
  initial begin : monitor
    bit pv;
    bit pa;
    int e;
    pv = 1'b0;
    pa = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tecla_valida === 1'b1 && (!pv || pa)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tecla_inesperada: tecla=%0d sin carga esperada t=%0t", bus.tecla, $time);
        end else begin
          e = exp_q.pop_front();
          chk("tecla_sb", {27'd0, bus.tecla}, e);
        end
      end
      pv = (bus.tecla_valida === 1'b1);
      pa = pv && (bus.tecla_ack === 1'b1);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: la simulacion no termino a tiempo");
    $fatal(1, "timeout");
  end

  initial begin : estimulo
    rst = 1'b1;
    pulsadas = 16'd0;
    bus.tecla_ack = 1'b0;

    // Reset held for 3 cycles
    ciclos(3);
    chk("reset_col", {28'd0, col}, 32'h1);
    chk("reset_tecla", {27'd0, bus.tecla}, 32'h1F);
    chk("reset_valida", {31'd0, bus.tecla_valida}, 32'h0);
    rst = 1'b0;

    // Idle rotation every DIV clocks
    for (int i = 1; i <= 4; i++) begin
      ciclos(DIV);
      chk("rotacion", {28'd0, col}, 32'd1 << (i % 4));
    end

    // Clean press of key 9 (col 2, row 1)
    esperar_col(4'b0100, 40);
    pulsadas[9] = 1'b1;
    esperar_valida(200);
    chk("limpia_tecla", {27'd0, bus.tecla}, 32'd9);
    chk("limpia_col_congelada", {28'd0, col}, 32'h4);
    bus.tecla_ack = 1'b1;
    ciclos(1);
    bus.tecla_ack = 1'b0;
    pulsadas = 16'd0;
    ciclos(2 * DIV);
    chk("soltar_col_congelada", {28'd0, col}, 32'h4);
    ciclos(30);

    // Bounce: key 0 seen for one tick only
    esperar_col(4'b1000, 40);
    esperar_col(4'b0001, 10);
    pulsadas[0] = 1'b1;
    ciclos(DIV);
    pulsadas = 16'd0;
    ciclos(DIV);
    chk("rebote_sin_tecla", {31'd0, bus.tecla_valida}, 32'h0);
    chk("rebote_col_siguiente", {28'd0, col}, 32'h2);

    // Multi-row: keys 1 and 2 give fila=0110 on col 0, lowest row wins
    pulsadas[1] = 1'b1;
    pulsadas[2] = 1'b1;
    esperar_valida(300);
    chk("multifila_tecla", {27'd0, bus.tecla}, 32'd1);
    bus.tecla_ack = 1'b1;
    ciclos(1);
    bus.tecla_ack = 1'b0;
    pulsadas = 16'd0;
    ciclos(30);

    // Handshake: key 9 unacked, key 5 dropped
    pulsadas[9] = 1'b1;
    esperar_valida(300);
    pulsadas = 16'd0;
    ciclos(30);
    pulsadas[5] = 1'b1;
    ciclos(120);
    pulsadas = 16'd0;
    ciclos(30);
    chk("descarte_tecla", {27'd0, bus.tecla}, 32'd9);
    chk("descarte_valida", {31'd0, bus.tecla_valida}, 32'h1);
`ifdef TECLADO_SOBRECARGA_EN
    chk("descarte_sobrecarga", {31'd0, sobrecarga}, 32'h1);
`endif

    // Ack on the accept cycle of key 14 (col 3, row 2): load wins
    esperar_col(4'b0100, 40);
    pulsadas[14] = 1'b1;
    esperar_col(4'b1000, 10);
    ciclos(3 * DIV - 1);
    bus.tecla_ack = 1'b1;
    ciclos(1);
    bus.tecla_ack = 1'b0;
    chk("ack_carga_tecla", {27'd0, bus.tecla}, 32'd14);
    chk("ack_carga_valida", {31'd0, bus.tecla_valida}, 32'h1);
    bus.tecla_ack = 1'b1;
    ciclos(1);
    bus.tecla_ack = 1'b0;
    pulsadas = 16'd0;
    ciclos(30);
    chk("vaciado_valida", {31'd0, bus.tecla_valida}, 32'h0);
    chk("vaciado_tecla", {27'd0, bus.tecla}, 32'h1F);

    // Randomized presses and acks against the model
    for (int it = 0; it < 25; it++) begin
      pulsadas = 16'd0;
      k = $urandom_range(0, 15);
      pulsadas[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, 15);
        pulsadas[k] = 1'b1;
      end
      hold = $urandom_range(2, 60);
      for (int c = 0; c < hold; c++) begin
        bus.tecla_ack = ($urandom_range(0, 2) == 0);
        ciclos(1);
      end
      pulsadas = 16'd0;
      hold = $urandom_range(0, 30);
      for (int c = 0; c < hold; c++) begin
        bus.tecla_ack = ($urandom_range(0, 2) == 0);
        ciclos(1);
      end
    end
    bus.tecla_ack = 1'b1;
    ciclos(40);
    bus.tecla_ack = 1'b0;

    // Reset while in release wait with a key buffered
    pulsadas[6] = 1'b1;
    esperar_valida(300);
    ciclos(DIV);
    rst = 1'b1;
    ciclos(1);
    chk("rst_medio_col", {28'd0, col}, 32'h1);
    chk("rst_medio_tecla", {27'd0, bus.tecla}, 32'h1F);
    chk("rst_medio_valida", {31'd0, bus.tecla_valida}, 32'h0);
`ifdef TECLADO_SOBRECARGA_EN
    chk("rst_medio_sobrecarga", {31'd0, sobrecarga}, 32'h0);
`endif
    rst = 1'b0;
    pulsadas = 16'd0;
    ciclos(20);

    chk("cola_final", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
